// File: rtl/bank_write_sequencer.sv
// Round-robin pixel bank writer filling double-buffered blocks between frame syncs.
// Optional dropped-pixel counter port: define BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN.
module bank_write_sequencer #(
    parameter int BANK_COUNT  = 3,
    parameter int BLOCK_DEPTH = 480,
    parameter int PIXEL_WIDTH = 24
) (
    input  logic                           I_clk,
    input  logic                           I_rst,
    input  logic                           I_vsync,
    input  logic                           I_de,
    input  logic [PIXEL_WIDTH-1:0]         I_pixel,
    input  logic                           I_block_free,
    output logic [$clog2(BLOCK_DEPTH)-1:0] O_global_address,
    output logic [BANK_COUNT-1:0]          O_bank_we,
    output logic [PIXEL_WIDTH-1:0]         O_bank_data,
    output logic                           O_block_sel,
    output logic                           O_block_done
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
    ,
    output logic [15:0]                    O_overflow_count
`endif
);

    localparam int AW = $clog2(BLOCK_DEPTH);
    localparam int BW = (BANK_COUNT > 1) ? $clog2(BANK_COUNT) : 1;

    localparam logic [AW-1:0]         ADDR_LAST = AW'(BLOCK_DEPTH - 1);
    localparam logic [AW-1:0]         ADDR_ONE  = AW'(1);
    localparam logic [BW-1:0]         BANK_LAST = BW'(BANK_COUNT - 1);
    localparam logic [BW-1:0]         BANK_ONE  = BW'(1);
    localparam logic [BANK_COUNT-1:0] WE_ONE    = BANK_COUNT'(1);

    typedef enum logic [1:0] {
        S_WAIT_FRAME = 2'd0,
        S_ACTIVE     = 2'd1,
        S_STALL      = 2'd2
    } state_t;

    state_t                   state_r, state_s;
    logic                     vsync_r;
    logic [BW-1:0]            bank_idx_r, bank_idx_s;
    logic [AW-1:0]            addr_r, addr_s;
    logic [AW-1:0]            gaddr_r, gaddr_s;
    logic [BANK_COUNT-1:0]    we_r, we_s;
    logic [PIXEL_WIDTH-1:0]   data_r, data_s;
    logic                     sel_r, sel_s;
    logic                     done_r, done_s;
    // Set alongside the final write so the buffer flips one cycle after it.
    logic                     toggle_pend_r, toggle_pend_s;
    logic                     vs_rise_s, vs_fall_s;
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
    logic [15:0]              ovf_r, ovf_s;
`endif

    assign vs_rise_s = I_vsync & ~vsync_r;
    assign vs_fall_s = ~I_vsync & vsync_r;

    // Next-state and next-output decode.
    always_comb begin
        state_s       = state_r;
        bank_idx_s    = bank_idx_r;
        addr_s        = addr_r;
        gaddr_s       = gaddr_r;
        we_s          = {BANK_COUNT{1'b0}};
        data_s        = data_r;
        done_s        = 1'b0;
        toggle_pend_s = 1'b0;
        if (toggle_pend_r) begin
            sel_s = ~sel_r;
        end else begin
            sel_s = sel_r;
        end
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
        ovf_s = ovf_r;
        if ((state_r == S_STALL) && I_de && (ovf_r != 16'hFFFF)) begin
            ovf_s = ovf_r + 16'd1;
        end else begin
            ovf_s = ovf_r;
        end
`endif

        if (vs_rise_s) begin
            // A new frame abandons any partial block without completing it.
            state_s = S_WAIT_FRAME;
        end else begin
            case (state_r)
                S_WAIT_FRAME: begin
                    if (vs_fall_s) begin
                        state_s    = S_ACTIVE;
                        bank_idx_s = {BW{1'b0}};
                        addr_s     = {AW{1'b0}};
                    end else begin
                        state_s = S_WAIT_FRAME;
                    end
                end
                S_ACTIVE: begin
                    if (I_de) begin
                        we_s    = WE_ONE << bank_idx_r;
                        data_s  = I_pixel;
                        gaddr_s = addr_r;
                        if (bank_idx_r == BANK_LAST) begin
                            bank_idx_s = {BW{1'b0}};
                            if (addr_r == ADDR_LAST) begin
                                addr_s = {AW{1'b0}};
                                done_s = 1'b1;
                                if (I_block_free) begin
                                    toggle_pend_s = 1'b1;
                                end else begin
                                    state_s = S_STALL;
                                end
                            end else begin
                                addr_s = addr_r + ADDR_ONE;
                            end
                        end else begin
                            bank_idx_s = bank_idx_r + BANK_ONE;
                        end
                    end else begin
                        bank_idx_s = bank_idx_r;
                    end
                end
                S_STALL: begin
                    if (I_block_free) begin
                        sel_s      = ~sel_s;
                        state_s    = S_ACTIVE;
                        bank_idx_s = {BW{1'b0}};
                        addr_s     = {AW{1'b0}};
                    end else begin
                        state_s = S_STALL;
                    end
                end
                default: begin
                    state_s = S_WAIT_FRAME;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_r       <= S_WAIT_FRAME;
            vsync_r       <= 1'b0;
            bank_idx_r    <= {BW{1'b0}};
            addr_r        <= {AW{1'b0}};
            gaddr_r       <= {AW{1'b0}};
            we_r          <= {BANK_COUNT{1'b0}};
            data_r        <= {PIXEL_WIDTH{1'b0}};
            sel_r         <= 1'b0;
            done_r        <= 1'b0;
            toggle_pend_r <= 1'b0;
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
            ovf_r         <= 16'd0;
`endif
        end else begin
            state_r       <= state_s;
            vsync_r       <= I_vsync;
            bank_idx_r    <= bank_idx_s;
            addr_r        <= addr_s;
            gaddr_r       <= gaddr_s;
            we_r          <= we_s;
            data_r        <= data_s;
            sel_r         <= sel_s;
            done_r        <= done_s;
            toggle_pend_r <= toggle_pend_s;
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
            ovf_r         <= ovf_s;
`endif
        end
    end

    assign O_global_address = gaddr_r;
    assign O_bank_we        = we_r;
    assign O_bank_data      = data_r;
    assign O_block_sel      = sel_r;
    assign O_block_done     = done_r;
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
    assign O_overflow_count = ovf_r;
`endif

endmodule

// File: tb/tb_bank_write_sequencer.sv
// Directed self-checking bench for bank_write_sequencer (default 3 banks x 480 words).
module tb_bank_write_sequencer;

    localparam int NB    = 3;
    localparam int DEPTH = 480;
    localparam int PW    = 24;
    localparam int LAST  = NB * DEPTH - 1;

    logic          I_clk = 1'b0;
    logic          I_rst = 1'b1;
    logic          I_vsync = 1'b0;
    logic          I_de = 1'b0;
    logic [PW-1:0] I_pixel = '0;
    logic          I_block_free = 1'b1;
    logic [8:0]    O_global_address;
    logic [NB-1:0] O_bank_we;
    logic [PW-1:0] O_bank_data;
    logic          O_block_sel;
    logic          O_block_done;
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
    logic [15:0]   O_overflow_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    bank_write_sequencer #(
        .BANK_COUNT(NB), .BLOCK_DEPTH(DEPTH), .PIXEL_WIDTH(PW)
    ) dut (
        .I_clk(I_clk), .I_rst(I_rst), .I_vsync(I_vsync), .I_de(I_de),
        .I_pixel(I_pixel), .I_block_free(I_block_free),
        .O_global_address(O_global_address), .O_bank_we(O_bank_we),
        .O_bank_data(O_bank_data), .O_block_sel(O_block_sel),
        .O_block_done(O_block_done)
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
        , .O_overflow_count(O_overflow_count)
`endif
    );

    always #5 I_clk = ~I_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge I_clk);
        #1;
    endtask

    function automatic logic [PW-1:0] pix_of(input int k);
        return PW'(k * 37 + 16);
    endfunction

    // Pixel k of a block lands in bank k%3 at address k/3; the last one closes the block.
    task automatic send_pix(input int k);
        logic [31:0] exp_we;
        exp_we  = 32'd1 << (k % NB);
        I_de    = 1'b1;
        I_pixel = pix_of(k);
        step();
        check_val("bank_we",   32'(O_bank_we), exp_we);
        check_val("address",   32'(O_global_address), 32'(k / NB));
        check_val("bank_data", 32'(O_bank_data), 32'(pix_of(k)));
        check_val("block_done", 32'(O_block_done), (k == LAST) ? 32'd1 : 32'd0);
    endtask

    task automatic idle_check(input string tag);
        step();
        check_val(tag, 32'(O_bank_we), 32'd0);
    endtask

    task automatic frame_start();
        I_de = 1'b0;
        I_vsync = 1'b1;
        step();
        I_vsync = 1'b0;
        step();
    endtask

    initial begin
        // Reset
        step();
        step();
        check_val("rst_we",    32'(O_bank_we), 32'd0);
        check_val("rst_data",  32'(O_bank_data), 32'd0);
        check_val("rst_addr",  32'(O_global_address), 32'd0);
        check_val("rst_sel",   32'(O_block_sel), 32'd0);
        check_val("rst_done",  32'(O_block_done), 32'd0);
        I_rst = 1'b0;

        // Pixels before any frame sync are ignored
        I_de = 1'b1;
        idle_check("pre_frame_we");

        // First nine pixels: 001,010,100 repeating, addresses 0,0,0,1,1,1,2,2,2
        frame_start();
        for (int k = 0; k < 9; k++) send_pix(k);

        // I_de toggling holds bank index and address
        I_de = 1'b0;
        idle_check("toggle_we_0");
        send_pix(9);
        I_de = 1'b0;
        idle_check("toggle_we_1");
        send_pix(10);
        for (int k = 11; k < 100; k++) send_pix(k);

        // Vsync rise with a pixel on the same cycle: pixel dropped, block abandoned
        I_vsync = 1'b1;
        I_de    = 1'b1;
        I_pixel = pix_of(100);
        step();
        check_val("vs_rise_we",   32'(O_bank_we), 32'd0);
        check_val("vs_rise_done", 32'(O_block_done), 32'd0);
        check_val("vs_rise_sel",  32'(O_block_sel), 32'd0);
        for (int i = 0; i < 3; i++) idle_check("vs_high_we");
        I_vsync = 1'b0;
        idle_check("vs_fall_we");

        // Full block with consumer ready: done with last pixel, sel flips
        I_block_free = 1'b1;
        for (int k = 0; k <= LAST; k++) send_pix(k);
        check_val("blk1_sel_at_done", 32'(O_block_sel), 32'd0);
        send_pix(0);
        check_val("blk2_sel", 32'(O_block_sel), 32'd1);

        // Block ends with consumer busy: stall, drop five pixels, then resume
        I_block_free = 1'b0;
        for (int k = 1; k <= LAST; k++) send_pix(k);
        for (int i = 0; i < 5; i++) begin
            I_de = 1'b1;
            I_pixel = 24'hABCDEF;
            step();
            check_val("stall_we",   32'(O_bank_we), 32'd0);
            check_val("stall_done", 32'(O_block_done), 32'd0);
        end
        check_val("stall_sel", 32'(O_block_sel), 32'd1);
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
        check_val("ovf_count_5", 32'(O_overflow_count), 32'd5);
`endif
        I_de = 1'b0;
        I_block_free = 1'b1;
        step();
        check_val("resume_sel", 32'(O_block_sel), 32'd0);
        check_val("resume_we",  32'(O_bank_we), 32'd0);
        for (int k = 0; k <= LAST; k++) send_pix(k);
        send_pix(0);
        check_val("blk4_sel", 32'(O_block_sel), 32'd1);

        // Stall again, then reset in the middle of it
        I_block_free = 1'b0;
        for (int k = 1; k <= LAST; k++) send_pix(k);
        I_de = 1'b1;
        idle_check("stall2_we");
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
        check_val("ovf_count_6", 32'(O_overflow_count), 32'd6);
`endif
        I_rst = 1'b1;
        step();
        check_val("srst_we",   32'(O_bank_we), 32'd0);
        check_val("srst_data", 32'(O_bank_data), 32'd0);
        check_val("srst_addr", 32'(O_global_address), 32'd0);
        check_val("srst_sel",  32'(O_block_sel), 32'd0);
        check_val("srst_done", 32'(O_block_done), 32'd0);
`ifdef BANK_WRITE_SEQUENCER_OVERFLOW_COUNT_EN
        check_val("srst_ovf",  32'(O_overflow_count), 32'd0);
`endif
        I_rst = 1'b0;
        I_block_free = 1'b1;
        for (int i = 0; i < 3; i++) idle_check("post_rst_wait_we");
        frame_start();
        send_pix(0);
        send_pix(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
